// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch-side PC sequencer: datapath width,
// sequential PC increment and the sequencer FSM state type.
package riscv_pkg;

    localparam int XLEN = 32;

    // Distance between consecutive instruction fetches.
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_MEM = 2'd2,
        ST_TRAP     = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: XLEN bits, asynchronous active-low reset to
// RESET_VALUE, loads d only when load is high.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    // PC storage with load enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// PC sequencer for the fetch stage. Walks the PC through instruction memory,
// waits on imem_ready, applies branch redirects (deferred while a fetch is
// outstanding) and trap redirects, and owns the fetch/decode register.
// Optional build macro: PC_SEQ_MISALIGN_TRAP_EN -- when defined, a branch to a
// non word-aligned target is turned into a trap; otherwise the low two target
// bits are cleared and the branch proceeds.
module pc_seq
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0004
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic            flush,
    output logic            trap_taken
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_load;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic            flush_q, flush_d;
    logic            trap_taken_q, trap_taken_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic [XLEN-1:0] br_tgt;
    logic            misalign;
    logic            take_trap;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    assign br_tgt   = br_target;
    assign misalign = br_taken && (br_target[1:0] != 2'b00);
`else
    assign br_tgt   = br_target & 32'hFFFF_FFFC;
    assign misalign = 1'b0;
`endif

    // A trap is honoured in every state but BOOT; misaligned branches only
    // matter where branches are accepted at all (RUN / WAIT_MEM).
    assign take_trap = ((state_q == ST_RUN) || (state_q == ST_WAIT_MEM)) ? (trap || misalign)
                                                                         : ((state_q == ST_TRAP) && trap);

    pc_reg #(
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_d),
        .q     (pc_q)
    );

    // Next-state, next-PC and fetch/decode register update; trap overrides all.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_load       = 1'b0;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        flush_d       = 1'b0;
        trap_taken_d  = 1'b0;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        imem_req      = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                imem_req = 1'b1;
                if (br_taken) begin
                    pc_d       = br_tgt;
                    pc_load    = 1'b1;
                    if_valid_d = 1'b0;
                    flush_d    = 1'b1;
                end else if (stall) begin
                    // Hold everything; memory acceptance this cycle is ignored.
                end else if (imem_ready) begin
                    pc_d       = pc_q + PC_INC;
                    pc_load    = 1'b1;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                imem_req = 1'b1;
                if (imem_ready && (br_taken || pend_valid_q)) begin
                    // Fetched word belongs to the wrong path: drop it.
                    pc_d         = br_taken ? br_tgt : pend_target_q;
                    pc_load      = 1'b1;
                    if_valid_d   = 1'b0;
                    flush_d      = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end else if (br_taken) begin
                    // Address must stay stable; remember the newest target.
                    pend_valid_d  = 1'b1;
                    pend_target_d = br_tgt;
                end else if (imem_ready && !stall) begin
                    pc_d       = pc_q + PC_INC;
                    pc_load    = 1'b1;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_TRAP: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (take_trap) begin
            state_d      = ST_TRAP;
            pc_d         = TRAP_VECTOR;
            pc_load      = 1'b1;
            if_valid_d   = 1'b0;
            flush_d      = 1'b1;
            trap_taken_d = 1'b1;
            pend_valid_d = 1'b0;
        end
    end

    // Sequencer state, fetch/decode register, pulses and pending redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            flush_q       <= 1'b0;
            trap_taken_q  <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            flush_q       <= flush_d;
            trap_taken_q  <= trap_taken_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign imem_addr  = pc_q;
    assign if_valid   = if_valid_q;
    assign if_pc      = if_pc_q;
    assign flush      = flush_q;
    assign trap_taken = trap_taken_q;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq. Each scenario builds a per-cycle table of
// inputs and expected outputs; rows go onto a scoreboard as they are driven
// and are popped and compared one clock later.
// Expected vector layout: {imem_req, imem_addr, if_valid, if_pc, flush, trap_taken}.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        trap = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        flush;
    logic        trap_taken;

    logic [67:0] obs;
    assign obs = {imem_req, imem_addr, if_valid, if_pc, flush, trap_taken};

    typedef struct {
        string       tag;
        logic        st;
        logic        br;
        logic [31:0] tgt;
        logic        tp;
        logic        rdy;
        logic [67:0] exp;
    } vec_t;

    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    pc_seq dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .trap       (trap),
        .imem_ready (imem_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .flush      (flush),
        .trap_taken (trap_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [67:0] ex(input logic req, input logic [31:0] a, input logic v,
                                       input logic [31:0] ipc, input logic fl, input logic tt);
        return {req, a, v, ipc, fl, tt};
    endfunction

    function automatic vec_t mk(input string tag, input logic st, input logic br,
                                input logic [31:0] tgt, input logic tp, input logic rdy,
                                input logic [67:0] e);
        vec_t r;
        r.tag = tag; r.st = st; r.br = br; r.tgt = tgt; r.tp = tp; r.rdy = rdy; r.exp = e;
        return r;
    endfunction

    // Apply one row's inputs and record its expectation on the scoreboard.
    task automatic drive_row(input vec_t r);
        stall = r.st; br_taken = r.br; br_target = r.tgt; trap = r.tp; imem_ready = r.rdy;
        sb.push_back(r);
    endtask

    // Assert reset, then release it away from the clock edge; DUT sits in BOOT.
    task automatic do_reset();
        stall = 1'b0; br_taken = 1'b0; br_target = '0; trap = 1'b0; imem_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        vec_t e;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = mk("reset_hold", 0, 0, 0, 0, 0, ex(0, 32'h0, 0, 32'h0, 0, 0));
        n_vec++;
        if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
        end else $display("ok   %s obs=%h", e.tag, obs);
        reset = 1'b1;
        #2;
        e = mk("boot_idle", 0, 0, 0, 0, 0, ex(0, 32'h0, 0, 32'h0, 0, 0));
        n_vec++;
        if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
        end else $display("ok   %s obs=%h", e.tag, obs);
    endtask

    task automatic test_fetch();
        vec_t v[$];
        vec_t e;
        do_reset();
        v.push_back(mk("fetch_boot", 0, 0, 0, 0, 1, ex(1, 32'h0, 0, 32'h0, 0, 0)));
        v.push_back(mk("fetch_a4",   0, 0, 0, 0, 1, ex(1, 32'h4, 1, 32'h0, 0, 0)));
        v.push_back(mk("fetch_a8",   0, 0, 0, 0, 1, ex(1, 32'h8, 1, 32'h4, 0, 0)));
        v.push_back(mk("fetch_aC",   0, 0, 0, 0, 1, ex(1, 32'hC, 1, 32'h8, 0, 0)));
        foreach (v[i]) begin
            drive_row(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
            end else $display("ok   %s obs=%h", e.tag, obs);
        end
    endtask

    task automatic test_wait_mem();
        vec_t v[$];
        vec_t e;
        do_reset();
        v.push_back(mk("wm_boot", 0, 0, 0, 0, 1, ex(1, 32'h0, 0, 32'h0, 0, 0)));
        v.push_back(mk("wm_f0",   0, 0, 0, 0, 1, ex(1, 32'h4, 1, 32'h0, 0, 0)));
        v.push_back(mk("wm_f1",   0, 0, 0, 0, 1, ex(1, 32'h8, 1, 32'h4, 0, 0)));
        for (int k = 0; k < 3; k++)
            v.push_back(mk($sformatf("wm_hold%0d", k), 0, 0, 0, 0, 0, ex(1, 32'h8, 1, 32'h4, 0, 0)));
        v.push_back(mk("wm_done", 0, 0, 0, 0, 1, ex(1, 32'hC, 1, 32'h8, 0, 0)));
        foreach (v[i]) begin
            drive_row(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
            end else $display("ok   %s obs=%h", e.tag, obs);
        end
    endtask

    task automatic test_branch_stall();
        vec_t v[$];
        vec_t e;
        do_reset();
        v.push_back(mk("br_boot", 0, 0, 0, 0, 1, ex(1, 32'h0, 0, 32'h0, 0, 0)));
        for (int k = 0; k < 4; k++)
            v.push_back(mk($sformatf("br_f%0d", k), 0, 0, 0, 0, 1,
                           ex(1, 32'(4 * (k + 1)), 1, 32'(4 * k), 0, 0)));
        v.push_back(mk("br_take",   1, 1, 32'h40, 0, 1, ex(1, 32'h40, 0, 32'hC, 1, 0)));
        v.push_back(mk("br_after",  0, 0, 0,      0, 1, ex(1, 32'h44, 1, 32'h40, 0, 0)));
        v.push_back(mk("stall0",    1, 0, 0,      0, 1, ex(1, 32'h44, 1, 32'h40, 0, 0)));
        v.push_back(mk("stall1",    1, 0, 0,      0, 1, ex(1, 32'h44, 1, 32'h40, 0, 0)));
        v.push_back(mk("stall_rel", 0, 0, 0,      0, 1, ex(1, 32'h48, 1, 32'h44, 0, 0)));
        foreach (v[i]) begin
            drive_row(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
            end else $display("ok   %s obs=%h", e.tag, obs);
        end
    endtask

    task automatic test_trap_branch();
        vec_t v[$];
        vec_t e;
        do_reset();
        v.push_back(mk("tb_boot",  0, 0, 0,      0, 1, ex(1, 32'h0, 0, 32'h0, 0, 0)));
        v.push_back(mk("tb_f0",    0, 0, 0,      0, 1, ex(1, 32'h4, 1, 32'h0, 0, 0)));
        v.push_back(mk("tb_f1",    0, 0, 0,      0, 1, ex(1, 32'h8, 1, 32'h4, 0, 0)));
        v.push_back(mk("tb_trap",  0, 1, 32'h80, 1, 1, ex(0, 32'h4, 0, 32'h4, 1, 1)));
        v.push_back(mk("tb_run",   0, 0, 0,      0, 1, ex(1, 32'h4, 0, 32'h4, 0, 0)));
        v.push_back(mk("tb_fetch", 0, 0, 0,      0, 1, ex(1, 32'h8, 1, 32'h4, 0, 0)));
        foreach (v[i]) begin
            drive_row(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
            end else $display("ok   %s obs=%h", e.tag, obs);
        end
    endtask

    task automatic test_wait_branch();
        vec_t v[$];
        vec_t e;
        do_reset();
        v.push_back(mk("wb_boot", 0, 0, 0, 0, 1, ex(1, 32'h0, 0, 32'h0, 0, 0)));
        for (int k = 0; k < 8; k++)
            v.push_back(mk($sformatf("wb_f%0d", k), 0, 0, 0, 0, 1,
                           ex(1, 32'(4 * (k + 1)), 1, 32'(4 * k), 0, 0)));
        v.push_back(mk("wb_wait",   0, 0, 0,       0, 0, ex(1, 32'h20, 1, 32'h1C, 0, 0)));
        v.push_back(mk("wb_br",     0, 1, 32'h60,  0, 0, ex(1, 32'h20, 1, 32'h1C, 0, 0)));
        v.push_back(mk("wb_hold",   0, 0, 0,       0, 0, ex(1, 32'h20, 1, 32'h1C, 0, 0)));
        v.push_back(mk("wb_drop",   0, 0, 0,       0, 1, ex(1, 32'h60, 0, 32'h1C, 1, 0)));
        v.push_back(mk("wb_f60",    0, 0, 0,       0, 1, ex(1, 32'h64, 1, 32'h60, 0, 0)));
        v.push_back(mk("ow_wait",   0, 0, 0,       0, 0, ex(1, 32'h64, 1, 32'h60, 0, 0)));
        v.push_back(mk("ow_br1",    0, 1, 32'h100, 0, 0, ex(1, 32'h64, 1, 32'h60, 0, 0)));
        v.push_back(mk("ow_br2",    0, 1, 32'h200, 0, 0, ex(1, 32'h64, 1, 32'h60, 0, 0)));
        v.push_back(mk("ow_drop",   0, 0, 0,       0, 1, ex(1, 32'h200, 0, 32'h60, 1, 0)));
        v.push_back(mk("ow_f200",   0, 0, 0,       0, 1, ex(1, 32'h204, 1, 32'h200, 0, 0)));
        v.push_back(mk("tc_wait",   0, 0, 0,       0, 0, ex(1, 32'h204, 1, 32'h200, 0, 0)));
        v.push_back(mk("tc_br",     0, 1, 32'h300, 0, 0, ex(1, 32'h204, 1, 32'h200, 0, 0)));
        v.push_back(mk("tc_trap",   0, 0, 0,       1, 0, ex(0, 32'h4, 0, 32'h200, 1, 1)));
        v.push_back(mk("tc_run",    0, 0, 0,       0, 0, ex(1, 32'h4, 0, 32'h200, 0, 0)));
        v.push_back(mk("tc_wait2",  0, 0, 0,       0, 0, ex(1, 32'h4, 0, 32'h200, 0, 0)));
        v.push_back(mk("tc_nopend", 0, 0, 0,       0, 1, ex(1, 32'h8, 1, 32'h4, 0, 0)));
        foreach (v[i]) begin
            drive_row(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
            end else $display("ok   %s obs=%h", e.tag, obs);
        end
    endtask

    task automatic test_misalign_wrap();
        vec_t v[$];
        vec_t e;
        do_reset();
        v.push_back(mk("ma_boot", 0, 0, 0,      0, 1, ex(1, 32'h0, 0, 32'h0, 0, 0)));
        v.push_back(mk("ma_f0",   0, 0, 0,      0, 1, ex(1, 32'h4, 1, 32'h0, 0, 0)));
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        v.push_back(mk("ma_br42", 0, 1, 32'h42, 0, 1, ex(0, 32'h4, 0, 32'h0, 1, 1)));
        v.push_back(mk("ma_next", 0, 0, 0,      0, 1, ex(1, 32'h4, 0, 32'h0, 0, 0)));
`else
        v.push_back(mk("ma_br42", 0, 1, 32'h42, 0, 1, ex(1, 32'h40, 0, 32'h0, 1, 0)));
        v.push_back(mk("ma_next", 0, 0, 0,      0, 1, ex(1, 32'h44, 1, 32'h40, 0, 0)));
`endif
        v.push_back(mk("wr_br",   0, 1, 32'hFFFF_FFFC, 0, 1, ex(1, 32'hFFFF_FFFC, 0, v[3].exp[33:2], 1, 0)));
        v.push_back(mk("wr_wrap", 0, 0, 0, 0, 1, ex(1, 32'h0, 1, 32'hFFFF_FFFC, 0, 0)));
        v.push_back(mk("wr_f0",   0, 0, 0, 0, 1, ex(1, 32'h4, 1, 32'h0, 0, 0)));
        foreach (v[i]) begin
            drive_row(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
            end else $display("ok   %s obs=%h", e.tag, obs);
        end
    endtask

    task automatic test_reset_mid_wait();
        vec_t v[$];
        vec_t e;
        do_reset();
        v.push_back(mk("rw_boot", 0, 0, 0, 0, 1, ex(1, 32'h0, 0, 32'h0, 0, 0)));
        v.push_back(mk("rw_f0",   0, 0, 0, 0, 1, ex(1, 32'h4, 1, 32'h0, 0, 0)));
        v.push_back(mk("rw_wait", 0, 0, 0, 0, 0, ex(1, 32'h4, 1, 32'h0, 0, 0)));
        foreach (v[i]) begin
            drive_row(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
            end else $display("ok   %s obs=%h", e.tag, obs);
        end
        // Asynchronous assertion between clock edges.
        #1 reset = 1'b0;
        #1;
        e = mk("rw_async", 0, 0, 0, 0, 0, ex(0, 32'h0, 0, 32'h0, 0, 0));
        n_vec++;
        if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
        end else $display("ok   %s obs=%h", e.tag, obs);
        do_reset();
        v.delete();
        v.push_back(mk("rw_boot2", 0, 0, 0, 0, 1, ex(1, 32'h0, 0, 32'h0, 0, 0)));
        v.push_back(mk("rw_f0b",   0, 0, 0, 0, 1, ex(1, 32'h4, 1, 32'h0, 0, 0)));
        foreach (v[i]) begin
            drive_row(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.exp);
            end else $display("ok   %s obs=%h", e.tag, obs);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_wait_mem();
        test_branch_stall();
        test_trap_branch();
        test_wait_branch();
        test_misalign_wrap();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
